chip8_alu_sequencer: RTL and testbench

Multi-cycle executor for Chip-8 8XYN arithmetic/logic instructions. It sits between the Chip8_CPU decode stage, the V-register file and Chip8_ALU, acting as the initiator side of the ALU interface:
- reads Vx and Vy;
- drives the ALU select and operands;
- writes back Vx and the VF flag;
- reports done or illegal to the CPU through a start/busy/done handshake.

---
 rtl/chip8_alu_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_chip8_alu_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_alu_sequencer.sv
// rtl/chip8_alu_sequencer.sv - multi-cycle Chip-8 8XYN executor between decode, V-register file and ALU
package chip8_alu_pkg;
  typedef enum logic [2:0] {
    ALU_f_OR     = 3'd0,
    ALU_f_AND    = 3'd1,
    ALU_f_XOR    = 3'd2,
    ALU_f_ADD    = 3'd3,
    ALU_f_MINUS  = 3'd4,
    ALU_f_RSHIFT = 3'd5,
    ALU_f_LSHIFT = 3'd6
  } ALU_f;
endpackage

module chip8_alu_sequencer
  import chip8_alu_pkg::*;
#(
  parameter bit QUIRK_VF_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] opcode,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  reg_addr,
  input  logic [7:0]  reg_rdata,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output ALU_f        alu_sel,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  input  logic [15:0] alu_out,
  input  logic        alu_carry
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_X  = 3'd1,
    RD_Y  = 3'd2,
    LATCH = 3'd3,
    EXEC  = 3'd4,
    WR_X  = 3'd5,
    WR_F  = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] x_q, y_q, n_q;
  logic       ill_q;
  logic [7:0] vx_q, vy_q, res_q;
  logic       flag_q, flag_nxt;
  logic       legal, flag_op, need_wf;
  logic       unused_alu_bits;

  assign unused_alu_bits = &{1'b0, alu_out[15:9]};

  assign legal   = (opcode[15:12] == 4'h8) && ((opcode[3] == 1'b0) || (opcode[3:0] == 4'hE));
  assign flag_op = (n_q == 4'h4) || (n_q == 4'h5) || (n_q == 4'h6) || (n_q == 4'h7) || (n_q == 4'hE);
  // The COSMAC quirk turns the logic ops into flag writers with a forced-zero flag.
  assign need_wf = flag_op || (QUIRK_VF_RESET && ((n_q == 4'h1) || (n_q == 4'h2) || (n_q == 4'h3)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      x_q    <= 4'h0;
      y_q    <= 4'h0;
      n_q    <= 4'h0;
      ill_q  <= 1'b0;
      vx_q   <= 8'h00;
      vy_q   <= 8'h00;
      res_q  <= 8'h00;
      flag_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        x_q   <= opcode[11:8];
        y_q   <= opcode[7:4];
        n_q   <= opcode[3:0];
        ill_q <= !legal;
      end
      if (state == RD_Y)  vx_q <= reg_rdata;
      if (state == LATCH) vy_q <= reg_rdata;
      if (state == EXEC) begin
        res_q  <= alu_out[7:0];
        flag_q <= flag_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    illegal   = 1'b0;
    reg_addr  = 4'h0;
    reg_wdata = 8'h00;
    reg_we    = 1'b0;
    alu_sel   = ALU_f_OR;
    alu_in1   = 16'h0000;
    alu_in2   = 16'h0000;
    flag_nxt  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = legal ? RD_X : DONE;
      RD_X: begin
        reg_addr  = x_q;
        state_nxt = RD_Y;
      end
      RD_Y: begin
        reg_addr  = y_q;
        state_nxt = LATCH;
      end
      LATCH: state_nxt = EXEC;
      EXEC: begin
        state_nxt = WR_X;
        case (n_q)
          4'h0: alu_in1 = {8'h00, vy_q};
          4'h1: begin
            alu_in1 = {8'h00, vx_q};
            alu_in2 = {8'h00, vy_q};
          end
          4'h2: begin
            alu_sel = ALU_f_AND;
            alu_in1 = {8'h00, vx_q};
            alu_in2 = {8'h00, vy_q};
          end
          4'h3: begin
            alu_sel = ALU_f_XOR;
            alu_in1 = {8'h00, vx_q};
            alu_in2 = {8'h00, vy_q};
          end
          4'h4: begin
            alu_sel  = ALU_f_ADD;
            alu_in1  = {8'h00, vx_q};
            alu_in2  = {8'h00, vy_q};
            flag_nxt = alu_out[8];
          end
          4'h5: begin
            alu_sel  = ALU_f_MINUS;
            alu_in1  = {8'h00, vx_q};
            alu_in2  = {8'h00, vy_q};
            flag_nxt = alu_carry;
          end
          4'h6: begin
            alu_sel  = ALU_f_RSHIFT;
            alu_in1  = {8'h00, vx_q};
            alu_in2  = 16'h0001;
            flag_nxt = vx_q[0];
          end
          4'h7: begin
            alu_sel  = ALU_f_MINUS;
            alu_in1  = {8'h00, vy_q};
            alu_in2  = {8'h00, vx_q};
            flag_nxt = alu_carry;
          end
          4'hE: begin
            alu_sel  = ALU_f_LSHIFT;
            alu_in1  = {8'h00, vx_q};
            alu_in2  = 16'h0001;
            flag_nxt = alu_out[8];
          end
          default: ;
        endcase
      end
      WR_X: begin
        reg_addr  = x_q;
        reg_wdata = res_q;
        reg_we    = 1'b1;
        state_nxt = need_wf ? WR_F : DONE;
      end
      WR_F: begin
        reg_addr  = 4'hF;
        reg_wdata = {7'b0, flag_q};
        reg_we    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        illegal   = ill_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// tb/tb_chip8_alu_sequencer.sv - directed self-checking bench for chip8_alu_sequencer
module tb_chip8_alu_sequencer;
  import chip8_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] opcode = 16'h0000;

  logic        busy0, done0, illegal0, we0, carry0;
  logic        busy1, done1, illegal1, we1, carry1;
  logic [3:0]  addr0, addr1;
  logic [7:0]  wdata0, wdata1, rdata0, rdata1;
  logic [15:0] in1_0, in2_0, aout0, in1_1, in2_1, aout1;
  ALU_f        sel0, sel1;

  logic [7:0]  regs0 [16];
  logic [7:0]  regs1 [16];
  logic        ld = 1'b0;
  logic [3:0]  ld_a = 4'h0;
  logic [7:0]  ld_d = 8'h00;

  int          comps = 0, errs = 0;
  bit          cur = 1'b0;
  int          nwr, done_cyc, extra;
  logic        ill_seen;
  logic [15:0] wr [4];

  logic        o_busy, o_done, o_illegal, o_we;
  logic [3:0]  o_addr;
  logic [7:0]  o_wdata;

  chip8_alu_sequencer #(.QUIRK_VF_RESET(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .opcode(opcode),
    .busy(busy0), .done(done0), .illegal(illegal0),
    .reg_addr(addr0), .reg_rdata(rdata0), .reg_wdata(wdata0), .reg_we(we0),
    .alu_sel(sel0), .alu_in1(in1_0), .alu_in2(in2_0), .alu_out(aout0), .alu_carry(carry0)
  );

  chip8_alu_sequencer #(.QUIRK_VF_RESET(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .opcode(opcode),
    .busy(busy1), .done(done1), .illegal(illegal1),
    .reg_addr(addr1), .reg_rdata(rdata1), .reg_wdata(wdata1), .reg_we(we1),
    .alu_sel(sel1), .alu_in1(in1_1), .alu_in2(in2_1), .alu_out(aout1), .alu_carry(carry1)
  );

  always #5 clk = ~clk;

  // Carry output for ADD is deliberately the inverse of bit 8, so a sequencer using it shows up.
  function automatic logic [16:0] alu_model(input ALU_f s, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        c;
    r = 16'h0000;
    c = 1'b0;
    case (s)
      ALU_f_OR:     r = a | b;
      ALU_f_AND:    r = a & b;
      ALU_f_XOR:    r = a ^ b;
      ALU_f_ADD:    begin r = a + b; c = ~r[8]; end
      ALU_f_MINUS:  begin r = a - b; c = (a > b); end
      ALU_f_RSHIFT: r = a >> b;
      ALU_f_LSHIFT: r = a << b;
      default:      r = 16'h0000;
    endcase
    return {c, r};
  endfunction

  assign {carry0, aout0} = alu_model(sel0, in1_0, in2_0);
  assign {carry1, aout1} = alu_model(sel1, in1_1, in2_1);

  always @(posedge clk) begin
    rdata0 <= regs0[addr0];
    rdata1 <= regs1[addr1];
    if (we0) regs0[addr0] <= wdata0;
    else if (ld) regs0[ld_a] <= ld_d;
    if (we1) regs1[addr1] <= wdata1;
    else if (ld) regs1[ld_a] <= ld_d;
  end

  assign o_busy    = cur ? busy1 : busy0;
  assign o_done    = cur ? done1 : done0;
  assign o_illegal = cur ? illegal1 : illegal0;
  assign o_we      = cur ? we1 : we0;
  assign o_addr    = cur ? addr1 : addr0;
  assign o_wdata   = cur ? wdata1 : wdata0;

  task automatic set_reg(input logic [3:0] a, input logic [7:0] d);
    ld = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Writes are logged as {cycle after start sample, addr, data}.
  task automatic run_op(input bit q, input logic [15:0] op, input int restart_at);
    nwr = 0; done_cyc = -1; ill_seen = 1'b0; extra = 0; cur = q;
    for (int i = 0; i < 4; i++) wr[i] = 16'h0000;
    opcode = op;
    if (q) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      if (o_we) begin
        if (nwr < 4) wr[nwr] = {k[3:0], o_addr, o_wdata};
        nwr++;
      end
      if (k == restart_at) begin
        if (q) start1 = 1'b1; else start0 = 1'b1;
      end
      if (o_done) begin
        done_cyc = k;
        ill_seen = o_illegal;
        break;
      end
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      if (o_busy || o_we || o_done) extra++;
    end
  endtask

  task automatic test_reset;
    comps++; if (busy0 !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy0); end
    comps++; if ({done0, illegal0, we0} !== 3'b000) begin errs++; $display("FAIL reset_pulses got %b want 000", {done0, illegal0, we0}); end
    comps++; if ({addr0, wdata0} !== 12'h000) begin errs++; $display("FAIL reset_reg_bus got %h want 000", {addr0, wdata0}); end
    comps++; if ({in1_0, in2_0} !== 32'h0) begin errs++; $display("FAIL reset_alu_in got %h want 0", {in1_0, in2_0}); end
    comps++; if (sel0 !== ALU_f_OR) begin errs++; $display("FAIL reset_alu_sel got %0d want %0d", sel0, ALU_f_OR); end
  endtask

  task automatic test_add;
    set_reg(4'h3, 8'h0F); set_reg(4'h5, 8'hF4);
    run_op(1'b0, 16'h8354, 0);
    comps++; if (done_cyc !== 7) begin errs++; $display("FAIL add_done got %0d want 7", done_cyc); end
    comps++; if (ill_seen !== 1'b0) begin errs++; $display("FAIL add_illegal got %b want 0", ill_seen); end
    comps++; if (nwr !== 2) begin errs++; $display("FAIL add_nwr got %0d want 2", nwr); end
    comps++; if (wr[0] !== 16'h5303) begin errs++; $display("FAIL add_wr_x got %h want 5303", wr[0]); end
    comps++; if (wr[1] !== 16'h6F01) begin errs++; $display("FAIL add_wr_f got %h want 6f01", wr[1]); end
    comps++; if (extra !== 0) begin errs++; $display("FAIL add_idle got %0d want 0", extra); end
  endtask

  task automatic test_sub;
    set_reg(4'h1, 8'h10); set_reg(4'h2, 8'h20);
    run_op(1'b0, 16'h8125, 0);
    comps++; if (done_cyc !== 7) begin errs++; $display("FAIL sub_done got %0d want 7", done_cyc); end
    comps++; if (wr[0] !== 16'h51F0) begin errs++; $display("FAIL sub_wr_x got %h want 51f0", wr[0]); end
    comps++; if (wr[1] !== 16'h6F00) begin errs++; $display("FAIL sub_wr_f got %h want 6f00", wr[1]); end
    set_reg(4'h1, 8'h10);
    run_op(1'b0, 16'h8127, 0);
    comps++; if (wr[0] !== 16'h5110) begin errs++; $display("FAIL subn_wr_x got %h want 5110", wr[0]); end
    comps++; if (wr[1] !== 16'h6F01) begin errs++; $display("FAIL subn_wr_f got %h want 6f01", wr[1]); end
  endtask

  task automatic test_shift;
    set_reg(4'h7, 8'h81);
    run_op(1'b0, 16'h870E, 0);
    comps++; if (wr[0] !== 16'h5702) begin errs++; $display("FAIL shl_wr_x got %h want 5702", wr[0]); end
    comps++; if (wr[1] !== 16'h6F01) begin errs++; $display("FAIL shl_wr_f got %h want 6f01", wr[1]); end
    set_reg(4'h7, 8'h81);
    run_op(1'b0, 16'h8706, 0);
    comps++; if (wr[0] !== 16'h5740) begin errs++; $display("FAIL shr_wr_x got %h want 5740", wr[0]); end
    comps++; if (wr[1] !== 16'h6F01) begin errs++; $display("FAIL shr_wr_f got %h want 6f01", wr[1]); end
    comps++; if (done_cyc !== 7) begin errs++; $display("FAIL shr_done got %0d want 7", done_cyc); end
  endtask

  task automatic test_quirk;
    set_reg(4'h4, 8'hAA); set_reg(4'h6, 8'h0F); set_reg(4'hF, 8'h55);
    run_op(1'b0, 16'h8462, 0);
    comps++; if (done_cyc !== 6) begin errs++; $display("FAIL and_q0_done got %0d want 6", done_cyc); end
    comps++; if (nwr !== 1) begin errs++; $display("FAIL and_q0_nwr got %0d want 1", nwr); end
    comps++; if (wr[0] !== 16'h540A) begin errs++; $display("FAIL and_q0_wr_x got %h want 540a", wr[0]); end
    comps++; if (regs0[15] !== 8'h55) begin errs++; $display("FAIL and_q0_vf got %h want 55", regs0[15]); end
    run_op(1'b1, 16'h8462, 0);
    comps++; if (done_cyc !== 7) begin errs++; $display("FAIL and_q1_done got %0d want 7", done_cyc); end
    comps++; if (nwr !== 2) begin errs++; $display("FAIL and_q1_nwr got %0d want 2", nwr); end
    comps++; if (wr[0] !== 16'h540A) begin errs++; $display("FAIL and_q1_wr_x got %h want 540a", wr[0]); end
    comps++; if (wr[1] !== 16'h6F00) begin errs++; $display("FAIL and_q1_wr_f got %h want 6f00", wr[1]); end
  endtask

  task automatic test_illegal;
    run_op(1'b0, 16'h8128, 1);
    comps++; if (done_cyc !== 1) begin errs++; $display("FAIL ill8_done got %0d want 1", done_cyc); end
    comps++; if (ill_seen !== 1'b1) begin errs++; $display("FAIL ill8_illegal got %b want 1", ill_seen); end
    comps++; if (nwr !== 0) begin errs++; $display("FAIL ill8_nwr got %0d want 0", nwr); end
    comps++; if (extra !== 0) begin errs++; $display("FAIL ill8_restart got %0d want 0", extra); end
    run_op(1'b0, 16'h7123, 0);
    comps++; if (done_cyc !== 1) begin errs++; $display("FAIL ill7_done got %0d want 1", done_cyc); end
    comps++; if (ill_seen !== 1'b1) begin errs++; $display("FAIL ill7_illegal got %b want 1", ill_seen); end
    comps++; if (nwr !== 0) begin errs++; $display("FAIL ill7_nwr got %0d want 0", nwr); end
  endtask

  task automatic test_back_to_back;
    set_reg(4'h3, 8'h0F); set_reg(4'h5, 8'hF4);
    run_op(1'b0, 16'h8354, 3);
    comps++; if (done_cyc !== 7) begin errs++; $display("FAIL busy_start_done got %0d want 7", done_cyc); end
    comps++; if (nwr !== 2) begin errs++; $display("FAIL busy_start_nwr got %0d want 2", nwr); end
    comps++; if (extra !== 0) begin errs++; $display("FAIL busy_start_idle got %0d want 0", extra); end
  endtask

  task automatic test_vf_dest;
    set_reg(4'hF, 8'hFF); set_reg(4'h1, 8'h01);
    run_op(1'b0, 16'h8F14, 0);
    comps++; if (wr[0] !== 16'h5F00) begin errs++; $display("FAIL vfx_wr_x got %h want 5f00", wr[0]); end
    comps++; if (wr[1] !== 16'h6F01) begin errs++; $display("FAIL vfx_wr_f got %h want 6f01", wr[1]); end
    comps++; if (regs0[15] !== 8'h01) begin errs++; $display("FAIL vfx_final got %h want 01", regs0[15]); end
  endtask

  task automatic test_reset_abort;
    int act;
    set_reg(4'hF, 8'hFF); set_reg(4'h1, 8'h01);
    cur = 1'b0;
    opcode = 16'h8F14; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    comps++; if (sel0 !== ALU_f_ADD) begin errs++; $display("FAIL abort_in_exec got %0d want %0d", sel0, ALU_f_ADD); end
    #2 reset_n = 1'b0;
    #1;
    comps++; if ({busy0, we0, done0} !== 3'b000) begin errs++; $display("FAIL abort_ctrl got %b want 000", {busy0, we0, done0}); end
    comps++; if ({in1_0, in2_0, addr0} !== 36'h0) begin errs++; $display("FAIL abort_bus got %h want 0", {in1_0, in2_0, addr0}); end
    @(negedge clk);
    reset_n = 1'b1;
    act = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (we0 || busy0) act++;
    end
    comps++; if (act !== 0) begin errs++; $display("FAIL abort_after got %0d want 0", act); end
    comps++; if (regs0[15] !== 8'hFF) begin errs++; $display("FAIL abort_vf got %h want ff", regs0[15]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      regs0[i] = 8'h00;
      regs1[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    test_reset;
    reset_n = 1'b1;
    @(negedge clk);
    test_add;
    test_sub;
    test_shift;
    test_quirk;
    test_illegal;
    test_back_to_back;
    test_vf_dest;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end

endmodule
